// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: fetch state encoding, datapath
// widths and the branch displacement helper.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // Sign-extend a 16-bit word offset and convert it to a byte displacement.
  function automatic logic [XLEN-1:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC candidate selection. Redirect priority is jump_reg, jump, branch,
// then sequential; only the selected candidate is checked for alignment.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] address,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  input  logic            jump_reg,
  input  logic [XLEN-1:0] reg_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] candidate,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] candidate_s;

  // Pick the highest-priority redirect; all additions wrap at 32 bits.
  always_comb begin
    pc_plus4_s  = address + 32'd4;
    candidate_s = pc_plus4_s;
    if (jump_reg) begin
      candidate_s = reg_target;
    end else if (jump) begin
      candidate_s = {pc_plus4_s[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      candidate_s = pc_plus4_s + branch_disp(branch_offset);
    end else begin
      candidate_s = pc_plus4_s;
    end
  end

  assign pc_plus4   = pc_plus4_s;
  assign candidate  = candidate_s;
  assign misaligned = (candidate_s[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: holds the PC, the RUN/HALT/FAULT
// state and a saturating count of PC advances.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               startin,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [15:0]        branch_offset,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  input  logic               jump_reg,
  input  logic [XLEN-1:0]    reg_target,
  output logic [XLEN-1:0]    address,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               running,
  output logic               halted,
  output logic               misaligned_fault,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  fetch_state_e     state_r, state_nxt_s;
  logic [XLEN-1:0]  address_r, address_nxt_s;
  logic [COUNT_W-1:0] count_r, count_nxt_s;
  logic [XLEN-1:0]  candidate_s;
  logic             misaligned_s;

  pc_next_mux u_next (
    .address       (address_r),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc_plus4      (pc_plus4),
    .candidate     (candidate_s),
    .misaligned    (misaligned_s)
  );

  // Next-state, next-PC and counter update; stall outranks halt and redirects.
  always_comb begin
    state_nxt_s   = state_r;
    address_nxt_s = address_r;
    count_nxt_s   = count_r;
    case (state_r)
      ST_RUN: begin
        if (stall) begin
          state_nxt_s = ST_RUN;
        end else if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (misaligned_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          address_nxt_s = candidate_s;
          if (count_r != COUNT_MAX) begin
            count_nxt_s = count_r + COUNT_ONE;
          end else begin
            count_nxt_s = count_r;
          end
        end
      end
      ST_HALT:  state_nxt_s = ST_HALT;
      ST_FAULT: state_nxt_s = ST_FAULT;
      // An unreachable encoding parks the stage in FAULT until restarted.
      default:  state_nxt_s = ST_FAULT;
    endcase
  end

  // State, PC and counter registers; startin overrides everything.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_r   <= ST_RUN;
      address_r <= RESET_PC;
      count_r   <= {COUNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      address_r <= address_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  assign address          = address_r;
  assign fetch_count      = count_r;
  assign running          = (state_r == ST_RUN);
  assign halted           = (state_r == ST_HALT);
  assign misaligned_fault = (state_r == ST_FAULT);

endmodule
